// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte sources.
// Supports owner locking for multi-byte messages, with an idle-lock timeout.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic [7:0] uart_data,
  output logic       uart_start,
  input  logic       uart_busy,
  output logic       owner,
  output logic       locked,
  output logic       idle
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [10:0] TIMER_MAX = 11'(LOCK_TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic [10:0] lock_timer;

  logic owner_valid;
  logic owner_lock;
  logic lock_drop;
  logic lock_wait;
  logic still_locked;
  logic elig_valid0;
  logic elig_valid1;
  logic grant;
  logic winner;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    owner_valid  = owner ? req1_valid : req0_valid;
    owner_lock   = owner ? req1_lock  : req0_lock;
    // A locked owner that still presents a byte keeps priority for it; the lock
    // is only given up early when the owner neither sends nor asks to keep it.
    lock_drop    = locked && !owner_valid && !owner_lock;
    lock_wait    = locked && !owner_valid &&  owner_lock;
    still_locked = locked && !lock_drop;
    elig_valid0  = req0_valid && (!still_locked || !owner);
    elig_valid1  = req1_valid && (!still_locked ||  owner);
    grant        = !uart_busy && (elig_valid0 || elig_valid1);
    winner       = (elig_valid0 && elig_valid1) ? ~last_grant : elig_valid1;
  end

  assign idle = (state == IDLE) && !uart_busy;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      uart_start <= 1'b0;
      uart_data  <= 8'h00;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      owner      <= 1'b0;
      locked     <= 1'b0;
      last_grant <= 1'b1;
      lock_timer <= '0;
    end else begin
      uart_start <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            uart_data  <= winner ? req1_data : req0_data;
            owner      <= winner;
            last_grant <= winner;
            locked     <= winner ? req1_lock : req0_lock;
            lock_timer <= '0;
            uart_start <= 1'b1;
            req0_ready <= ~winner;
            req1_ready <= winner;
            state      <= LAUNCH;
          end else if (lock_drop) begin
            locked     <= 1'b0;
            lock_timer <= '0;
          end else if (lock_wait) begin
            if (lock_timer == TIMER_MAX) begin
              locked     <= 1'b0;
              lock_timer <= '0;
            end else begin
              lock_timer <= lock_timer + 11'd1;
            end
          end
        end
        LAUNCH:    state <= WAIT_BUSY;
        WAIT_BUSY: if (uart_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!uart_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
